txn_seq_arbiter: RTL and testbench
==================================

// Module: txn_seq_arbiter
// PURPOSE
//   Shares one two-acknowledge transaction resource among NREQ requesters.
//   Grants round-robin, pulses start, collects ack_a and ack_b in any order,
//   then pulses done one cycle after the last ack.
//   Sits between the requesting agents and the resource that asserts the acks.
// PARAMETERS
//   NREQ     4   number of requesters, 2..16
//   TIMEOUT  16  max WAIT cycles before abort; used only when SEQ_TIMEOUT_EN is defined; >=2
//   IDW      $clog2(NREQ)  localparam, width of gnt_id
// PORTS
//   clk     in   1     single clock, posedge
//   rst_n   in   1     asynchronous active-low reset
//   req     in   NREQ  request per requester; held high until its done/err
//   gnt     out  NREQ  one-hot grant, held from ISSUE through DONE/ABORT
//   gnt_id  out  IDW   index of the granted requester (valid while busy)
//   start   out  1     one-cycle transaction launch to the resource
//   ack_a   in   1     resource acknowledge A, single-cycle pulse
//   ack_b   in   1     resource acknowledge B, single-cycle pulse
//   done    out  1     one-cycle completion pulse
//   err     out  1     one-cycle timeout pulse (0 without SEQ_TIMEOUT_EN)
//   busy    out  1     high in every state except IDLE
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; gnt=0, gnt_id=0, start=0, done=0,
//     err=0, busy=0; priority pointer=0; ack flags and timer cleared.
//   FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE  (WAIT -> ABORT -> IDLE with macro).
//   IDLE: if |req, pick the first set req at or above the pointer, wrapping
//     modulo NREQ; register gnt/gnt_id; next state ISSUE. All acks are ignored.
//   ISSUE: start=1 for exactly this cycle; ack flags cleared; -> WAIT.
//     Acks present in the ISSUE cycle are ignored.
//   WAIT: seen_a |= ack_a, seen_b |= ack_b (sticky). Leave WAIT in the cycle
//     both flags are set, counting acks arriving this cycle. Simultaneous
//     ack_a and ack_b complete in one cycle. Repeated acks are harmless.
//   DONE: done=1 for one cycle, so done rises one clk after the final ack;
//     pointer = gnt_id+1 (wraps NREQ-1 -> 0); gnt cleared on exit -> IDLE.
//   Minimum turnaround is 4 cycles (grant, ISSUE, WAIT, DONE). A new grant
//     can be made only in IDLE; there is no back-to-back DONE->ISSUE.
//   req deassert during ISSUE/WAIT: the transaction still runs to done/err.
//   Fairness: a continuously requesting agent is granted within NREQ
//     transactions.
//   Reset mid-transaction: immediate return to reset values; no done/err pulse.
// CONFIGURATION
//   SEQ_TIMEOUT_EN defined: a timer counts WAIT cycles from 0. If the timer
//     reaches TIMEOUT-1 with an ack still missing -> ABORT: err=1 for one cycle,
//     pointer advances as in DONE, -> IDLE. Completion in the last allowed cycle
//     takes priority over the timeout.
//   Not defined: no timer; WAIT holds indefinitely; err tied to 0.
// STRUCTURE
//   Package txn_seq_pkg: state enum typedef (IDLE, ISSUE, WAIT, DONE, ABORT)
//     and a TIMEOUT default constant.
//   Sub-module rr_pick: combinational round-robin selector; inputs req and
//     pointer; outputs one-hot gnt and id. Everything else stays in the top.
// TESTING
//   1 Reset: rst_n=0 -> all outputs 0. Release, req=0 for 10 cycles -> busy
//     stays 0 and start never pulses.
//   2 Single txn: req=4'b0001. ack_a 2 cycles after start, ack_b 4 cycles after
//     start -> start pulses once, gnt_id=0, done exactly 1 cycle after ack_b.
//   3 Simultaneous acks: ack_a and ack_b in the same cycle, 1 cycle after start
//     -> done the next cycle; acks in the ISSUE cycle alone -> no done.
//   4 Round-robin: req=4'b1011 held, acks always returned -> grant order
//     0,1,3,0,1,3; with req=4'b1000 only -> 3 repeated.
//   5 Timeout (SEQ_TIMEOUT_EN, TIMEOUT=16): only ack_a returned -> err 1-cycle
//     pulse, no done; next grant goes to the next requester. Without the macro
//     -> busy stays 1 and err stays 0.
//   6 Async reset asserted mid-WAIT -> outputs 0 immediately, no done; after
//     release with req=4'b0100 -> gnt_id=2 (pointer back at 0).

Source files
------------

// File: rtl/txn_seq_pkg.sv
// Shared types for the two-ack transaction sequencer.
// State encoding and default timeout depth.
package txn_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE,
        ABORT
    } state_t;

    localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/txn_seq_arbiter_rr_pick.sv
// Combinational round-robin selector.
// First set req at or above ptr, wrapping modulo NREQ.
module rr_pick
    import txn_seq_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  id
);

    int             j;
    logic [IDW-1:0] idx;
    logic           found;

    // scan from ptr upward and take the first requester seen
    always_comb begin
        gnt   = '0;
        id    = '0;
        found = 1'b0;
        j     = 0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            idx = IDW'(j);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                id       = idx;
            end
        end
    end

endmodule

// File: rtl/txn_seq_arbiter.sv
// Round-robin owner of a two-acknowledge transaction resource.
// Optional WAIT timeout enabled by defining SEQ_TIMEOUT_EN.
module txn_seq_arbiter
    import txn_seq_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int TIMEOUT = TIMEOUT_DEF,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            start,
    input  logic            ack_a,
    input  logic            ack_b,
    output logic            done,
    output logic            err,
    output logic            busy
);

    if (NREQ < 2 || NREQ > 16 || TIMEOUT < 2) begin : g_bad_cfg
        $error("txn_seq_arbiter: NREQ must be 2..16, TIMEOUT >= 2");
    end

    state_t          state;
    state_t          nstate;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  next_ptr;
    logic [NREQ-1:0] pick_gnt;
    logic [IDW-1:0]  pick_id;
    logic            seen_a;
    logic            seen_b;
    logic            both;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .id  (pick_id)
    );

    assign both     = (seen_a | ack_a) & (seen_b | ack_b);
    assign next_ptr = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);

    logic [TW-1:0] timer;
    logic          expired;

    assign expired = (timer == TW'(TIMEOUT - 1));

    // WAIT cycle counter, restarted on every launch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (state == ISSUE) begin
            timer <= '0;
        end else if (state == WAIT) begin
            timer <= timer + 1'b1;
        end
    end
`endif

    // next-state and Moore outputs
    always_comb begin
        nstate = state;
        start  = 1'b0;
        done   = 1'b0;
        err    = 1'b0;
        busy   = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (|req) nstate = ISSUE;
            end
            ISSUE: begin
                start  = 1'b1;
                nstate = WAIT;
            end
            WAIT: begin
                if (both) begin
                    nstate = DONE;
`ifdef SEQ_TIMEOUT_EN
                end else if (expired) begin
                    nstate = ABORT;
`endif
                end
            end
            DONE: begin
                done   = 1'b1;
                nstate = IDLE;
            end
            ABORT: begin
`ifdef SEQ_TIMEOUT_EN
                err    = 1'b1;
`endif
                nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
    end

    // state, grant, pointer and sticky ack flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            gnt    <= '0;
            gnt_id <= '0;
            ptr    <= '0;
            seen_a <= 1'b0;
            seen_b <= 1'b0;
        end else begin
            state <= nstate;
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        gnt    <= pick_gnt;
                        gnt_id <= pick_id;
                    end
                end
                ISSUE: begin
                    seen_a <= 1'b0;
                    seen_b <= 1'b0;
                end
                WAIT: begin
                    seen_a <= seen_a | ack_a;
                    seen_b <= seen_b | ack_b;
                end
                DONE, ABORT: begin
                    gnt <= '0;
                    ptr <= next_ptr;
                end
                default: gnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_txn_seq_arbiter.sv
// Self-checking bench for txn_seq_arbiter.
// Random ack timing and request patterns against a round-robin model.
module tb_txn_seq_arbiter;

    localparam int NREQ = 4;
    localparam int TMO  = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req   = '0;
    logic       ack_a = 1'b0;
    logic       ack_b = 1'b0;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       start;
    logic       done;
    logic       err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int ptr_m  = 0;

    always #5 clk = ~clk;

    txn_seq_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TMO)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .start  (start),
        .ack_a  (ack_a),
        .ack_b  (ack_b),
        .done   (done),
        .err    (err),
        .busy   (busy)
    );

    function automatic int model_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (start === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // drive acks at offsets da/db from the current cycle, watch outcome
    task automatic run_acks(input int da, input int db, input int bound,
                            output int lat, output int kind,
                            output int nstart, output int nerr);
        lat = 0; kind = 0; nstart = 0; nerr = 0;
        for (int c = 0; c < bound; c++) begin
            ack_a = (c == da);
            ack_b = (c == db);
            tick();
            ack_a = 1'b0;
            ack_b = 1'b0;
            if (start === 1'b1) nstart++;
            if (err === 1'b1) nerr++;
            if (done === 1'b1) begin
                lat = c + 1; kind = 1;
                break;
            end
            if (err === 1'b1) begin
                lat = c + 1; kind = 2;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        ack_a = 1'b0;
        ack_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
    endtask

    task automatic test_reset();
        int nbusy;
        int nstart;
        rst_n = 1'b0;
        #12;
        checks++;
        if (gnt !== 4'b0) begin
            errors++; $display("FAIL rst_gnt: got %b want 0000", gnt);
        end
        checks++;
        if (gnt_id !== 2'd0) begin
            errors++; $display("FAIL rst_gnt_id: got %0d want 0", gnt_id);
        end
        checks++;
        if (start !== 1'b0) begin
            errors++; $display("FAIL rst_start: got %b want 0", start);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL rst_done: got %b want 0", done);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL rst_err: got %b want 0", err);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL rst_busy: got %b want 0", busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
        nbusy = 0;
        nstart = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy !== 1'b0) nbusy++;
            if (start !== 1'b0) nstart++;
        end
        checks++;
        if (nbusy != 0) begin
            errors++; $display("FAIL idle_busy: got %0d busy cycles want 0", nbusy);
        end
        checks++;
        if (nstart != 0) begin
            errors++; $display("FAIL idle_start: got %0d starts want 0", nstart);
        end
    endtask

    task automatic test_single();
        bit ok;
        int exp, lat, kind, ns, ne;
        req = 4'b0001;
        exp = model_pick(req, ptr_m);
        wait_start(ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL single_start: got no start want start");
        end
        checks++;
        if (int'(gnt_id) != exp) begin
            errors++; $display("FAIL single_id: got %0d want %0d", gnt_id, exp);
        end
        checks++;
        if (gnt !== 4'b0001) begin
            errors++; $display("FAIL single_gnt: got %b want 0001", gnt);
        end
        run_acks(2, 4, 20, lat, kind, ns, ne);
        req = '0;
        ptr_m = (exp + 1) % NREQ;
        checks++;
        if (kind != 1 || lat != 5) begin
            errors++;
            $display("FAIL single_done: got kind %0d lat %0d want kind 1 lat 5", kind, lat);
        end
        checks++;
        if (ns != 0) begin
            errors++; $display("FAIL single_nstart: got %0d extra starts want 0", ns);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || gnt !== 4'b0) begin
            errors++;
            $display("FAIL single_after: got done %b busy %b gnt %b want 0 0 0000",
                     done, busy, gnt);
        end
    endtask

    task automatic test_simul();
        bit ok;
        int exp, lat, kind, ns, ne;
        req = 4'b0010;
        exp = model_pick(req, ptr_m);
        wait_start(ok);
        checks++;
        if (!ok || int'(gnt_id) != exp) begin
            errors++; $display("FAIL simul_id: got %0d want %0d", gnt_id, exp);
        end
        run_acks(1, 1, 20, lat, kind, ns, ne);
        req = '0;
        ptr_m = (exp + 1) % NREQ;
        checks++;
        if (kind != 1 || lat != 2) begin
            errors++;
            $display("FAIL simul_done: got kind %0d lat %0d want kind 1 lat 2", kind, lat);
        end
        tick();
        req = 4'b0100;
        exp = model_pick(req, ptr_m);
        wait_start(ok);
        checks++;
        if (!ok || int'(gnt_id) != exp) begin
            errors++; $display("FAIL issue_id: got %0d want %0d", gnt_id, exp);
        end
        run_acks(0, 0, 8, lat, kind, ns, ne);
        checks++;
        if (kind != 0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL issue_ack_ignored: got kind %0d busy %b want kind 0 busy 1",
                     kind, busy);
        end
        run_acks(0, 0, 20, lat, kind, ns, ne);
        req = '0;
        ptr_m = (exp + 1) % NREQ;
        checks++;
        if (kind != 1 || lat != 1) begin
            errors++;
            $display("FAIL issue_late_done: got kind %0d lat %0d want kind 1 lat 1",
                     kind, lat);
        end
        tick();
    endtask

    task automatic test_round_robin();
        bit ok;
        int exp, lat, kind, ns, ne, da, db;
        int order [6] = '{0, 1, 3, 0, 1, 3};
        apply_reset();
        req = 4'b1011;
        for (int k = 0; k < 25; k++) begin
            if (k == 6) req = 4'b1000;
            if (k >= 9) req = 4'($urandom_range(1, 15));
            exp = model_pick(req, ptr_m);
            wait_start(ok);
            da = $urandom_range(1, 6);
            db = $urandom_range(1, 6);
            checks++;
            if (!ok || int'(gnt_id) != exp) begin
                errors++;
                $display("FAIL rr_id[%0d]: got %0d want %0d req %b", k, gnt_id, exp, req);
            end
            if (k < 6) begin
                checks++;
                if (int'(gnt_id) != order[k]) begin
                    errors++;
                    $display("FAIL rr_order[%0d]: got %0d want %0d", k, gnt_id, order[k]);
                end
            end else if (k < 9) begin
                checks++;
                if (gnt_id !== 2'd3) begin
                    errors++; $display("FAIL rr_only3[%0d]: got %0d want 3", k, gnt_id);
                end
            end
            checks++;
            if (gnt !== (4'b0001 << exp)) begin
                errors++; $display("FAIL rr_gnt[%0d]: got %b want one-hot %0d", k, gnt, exp);
            end
            run_acks(da, db, 20, lat, kind, ns, ne);
            ptr_m = (exp + 1) % NREQ;
            checks++;
            if (kind != 1 || lat != imax(da, db) + 1 || ns != 0) begin
                errors++;
                $display("FAIL rr_done[%0d]: got kind %0d lat %0d starts %0d want 1 %0d 0",
                         k, kind, lat, ns, imax(da, db) + 1);
            end
        end
        req = '0;
        tick();
    endtask

    task automatic test_timeout();
        bit ok;
        int exp, lat, kind, ns, ne;
        req = 4'b0011;
        exp = model_pick(req, ptr_m);
        wait_start(ok);
        checks++;
        if (!ok || int'(gnt_id) != exp) begin
            errors++; $display("FAIL tmo_id: got %0d want %0d", gnt_id, exp);
        end
`ifdef SEQ_TIMEOUT_EN
        run_acks(1, 1000, 40, lat, kind, ns, ne);
        ptr_m = (exp + 1) % NREQ;
        checks++;
        if (kind != 2 || lat != TMO + 1 || ne != 1) begin
            errors++;
            $display("FAIL tmo_err: got kind %0d lat %0d errs %0d want 2 %0d 1",
                     kind, lat, ne, TMO + 1);
        end
        tick();
        checks++;
        if (err !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL tmo_after: got err %b done %b busy %b want 0 0 0",
                     err, done, busy);
        end
        exp = model_pick(req, ptr_m);
        wait_start(ok);
        checks++;
        if (!ok || int'(gnt_id) != exp) begin
            errors++; $display("FAIL tmo_next_id: got %0d want %0d", gnt_id, exp);
        end
        run_acks(1, TMO, 40, lat, kind, ns, ne);
        ptr_m = (exp + 1) % NREQ;
        checks++;
        if (kind != 1 || lat != TMO + 1 || ne != 0) begin
            errors++;
            $display("FAIL tmo_last_cycle: got kind %0d lat %0d errs %0d want 1 %0d 0",
                     kind, lat, ne, TMO + 1);
        end
`else
        run_acks(1, 1000, 40, lat, kind, ns, ne);
        checks++;
        if (kind != 0 || ne != 0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL tmo_hold: got kind %0d errs %0d busy %b want 0 0 1",
                     kind, ne, busy);
        end
        run_acks(1000, 0, 20, lat, kind, ns, ne);
        ptr_m = (exp + 1) % NREQ;
        checks++;
        if (kind != 1 || lat != 1) begin
            errors++;
            $display("FAIL tmo_finish: got kind %0d lat %0d want 1 1", kind, lat);
        end
`endif
        req = '0;
        tick();
    endtask

    task automatic test_async_reset();
        bit ok;
        int exp, lat, kind, ns, ne, ndone;
        req = 4'b0010;
        wait_start(ok);
        run_acks(1000, 1, 3, lat, kind, ns, ne);
        checks++;
        if (!ok || busy !== 1'b1 || gnt !== 4'b0010) begin
            errors++;
            $display("FAIL arst_pre: got busy %b gnt %b want 1 0010", busy, gnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0 || gnt_id !== 2'd0 || start !== 1'b0 ||
            done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL arst_now: got gnt %b id %0d s %b d %b e %b b %b want all 0",
                     gnt, gnt_id, start, done, err, busy);
        end
        req = '0;
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done !== 1'b0 || err !== 1'b0) ndone++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
        checks++;
        if (ndone != 0) begin
            errors++; $display("FAIL arst_pulse: got %0d pulses want 0", ndone);
        end
        req = 4'b0100;
        exp = model_pick(req, ptr_m);
        wait_start(ok);
        checks++;
        if (!ok || int'(gnt_id) != exp || gnt_id !== 2'd2) begin
            errors++; $display("FAIL arst_id: got %0d want 2", gnt_id);
        end
        run_acks(1, 1, 20, lat, kind, ns, ne);
        checks++;
        if (kind != 1 || lat != 2) begin
            errors++;
            $display("FAIL arst_done: got kind %0d lat %0d want 1 2", kind, lat);
        end
        req = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_simul();
        test_round_robin();
        test_timeout();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
